// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver:
// parity mode codes, receiver FSM state type and the expected-parity helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Value the parity bit must carry, given the XOR-reduction of the data word.
  function automatic logic parity_expected(input int mode, input logic data_xor);
    logic res;
    case (mode)
      PARITY_ODD:  res = ~data_xor;
      PARITY_EVEN: res = data_xor;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad plus falling-edge detect.
// All flops reset to 1 (line idle level) so leaving reset never fakes a start edge.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic sync_q1;
  logic sync_q2;
  logic rx_s_d;

  // Metastability filter followed by one extra delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      sync_q1 <= rx;
      sync_q2 <= sync_q1;
      rx_s_d  <= sync_q2;
    end
  end

  assign rx_s    = sync_q2;
  assign rx_fall = rx_s_d & ~sync_q2;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with false-start rejection,
// valid/ready output handshake, overrun detection and per-frame error flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of
// the samples around the bit centre, decided one cycle after the centre.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 2,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 err_parity,
  output logic                 err_frame,
  output logic                 err_overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [OW-1:0] OVS_LAST  = OW'(OVS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [OW-1:0] PRE_PT    = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] MID_PT    = OW'(OVS / 2);
  localparam logic [OW-1:0] DECIDE_PT = OW'(OVS / 2 + 1);
`else
  localparam logic [OW-1:0] DECIDE_PT = OW'(OVS / 2);
`endif

  logic rx_s;
  logic rx_fall;

  rx_state_t state_q, state_n;
  logic [OW-1:0]        ovs_cnt, ovs_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 perr_q, perr_n;
  logic                 ferr_q, ferr_n;
  logic                 complete;
  logic                 bit_val;
  logic                 decide;
  logic                 bit_end;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic maj_s0;
  logic maj_s1;

  // Capture the two samples preceding the decision point for the majority vote.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      maj_s0 <= 1'b1;
      maj_s1 <= 1'b1;
    end else begin
      if (ovs_cnt == PRE_PT) maj_s0 <= rx_s;
      if (ovs_cnt == MID_PT) maj_s1 <= rx_s;
    end
  end

  assign bit_val = (maj_s0 & maj_s1) | (maj_s0 & rx_s) | (maj_s1 & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign decide  = (ovs_cnt == DECIDE_PT);
  assign bit_end = (ovs_cnt == OVS_LAST);
  assign busy    = (state_q != ST_IDLE);

  // State, oversample/bit counters, shift register and error accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ovs_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ovs_cnt <= ovs_n;
      bit_cnt <= bit_n;
      shift_q <= shift_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
    end
  end

  // Frame sequencing: bit timing, sampling decisions and frame completion.
  always_comb begin
    state_n  = state_q;
    ovs_n    = ovs_cnt + 1'b1;
    bit_n    = bit_cnt;
    shift_n  = shift_q;
    perr_n   = perr_q;
    ferr_n   = ferr_q;
    complete = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ovs_n = '0;
        bit_n = '0;
        if (rx_fall) begin
          state_n = ST_START;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end

      ST_START: begin
        if (decide && bit_val) begin
          state_n = ST_IDLE;
          ovs_n   = '0;
        end else if (bit_end) begin
          state_n = ST_DATA;
          ovs_n   = '0;
          bit_n   = '0;
        end
      end

      ST_DATA: begin
        if (decide) begin
          shift_n = {bit_val, shift_q[DATA_BITS-1:1]};
        end
        if (bit_end) begin
          ovs_n = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (decide) begin
          perr_n = (bit_val != parity_expected(PARITY, ^shift_q));
        end
        if (bit_end) begin
          state_n = ST_STOP;
          ovs_n   = '0;
          bit_n   = '0;
        end
      end

      ST_STOP: begin
        if (decide) begin
          if (!bit_val) ferr_n = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            complete = 1'b1;
            state_n  = ST_IDLE;
            ovs_n    = '0;
            bit_n    = '0;
          end
        end else if (bit_end) begin
          ovs_n = '0;
          bit_n = bit_cnt + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        ovs_n   = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Output word register and valid/ready handshake; a held word is never overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      if (complete && (!rx_valid || rx_ready)) begin
        rx_data    <= shift_q;
        err_parity <= perr_q;
        err_frame  <= ferr_n;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Sticky overrun flag; a new overrun outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
    end else if (complete && rx_valid && !rx_ready) begin
      err_overrun <= 1'b1;
    end else if (err_clr) begin
      err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param (OVS=16, 8 data bits, even parity, 1 stop).
// A second instance with odd parity shares the rx line for the parity-mode check.
module tb_uart_rx_param;

  localparam int OVS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       err_parity;
  logic       err_frame;
  logic       err_overrun;
  logic       busy;

  logic [7:0] odd_data;
  logic       odd_valid;
  logic       odd_err_parity;
  logic       odd_err_frame;
  logic       odd_err_overrun;
  logic       odd_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   odd_cnt = 0;
  logic odd_perr_last = 1'b1;
  logic [7:0] odd_data_last = 8'h00;

  uart_rx_param #(.OVS(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_overrun (err_overrun),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  uart_rx_param #(.OVS(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_odd (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_data     (odd_data),
    .rx_valid    (odd_valid),
    .rx_ready    (1'b1),
    .err_parity  (odd_err_parity),
    .err_frame   (odd_err_frame),
    .err_overrun (odd_err_overrun),
    .err_clr     (1'b0),
    .busy        (odd_busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    tick(OVS);
  endtask

  // One full frame: start, 8 data bits LSB first, parity bit, stop bit, short idle gap.
  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                               input logic push, input logic exp_perr, input logic exp_ferr);
    exp_t e;
    if (push) begin
      e.data = data;
      e.perr = exp_perr;
      e.ferr = exp_ferr;
      exp_q.push_back(e);
    end
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
    sendBit(par);
    sendBit(stop);
    rx = 1'b1;
    tick(4);
  endtask

  // Monitor: every accepted word is matched against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_word: got %0h, expected no word", rx_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rx_data", rx_data, e.data);
        checkOutput("err_parity", err_parity, e.perr);
        checkOutput("err_frame", err_frame, e.ferr);
      end
    end
  end

  // Records what the odd-parity instance delivers.
  always @(negedge clk) begin
    if (rst_n && odd_valid) begin
      odd_cnt++;
      odd_perr_last = odd_err_parity;
      odd_data_last = odd_data;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    tick(3);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_err_parity", err_parity, 0);
    checkOutput("reset_err_frame", err_frame, 0);
    checkOutput("reset_err_overrun", err_overrun, 0);
    checkOutput("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);

    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    c0 = odd_cnt;
    applyStimulus(8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("odd_word_count", odd_cnt - c0, 1);
    checkOutput("odd_rx_data", odd_data_last, 8'h01);
    checkOutput("odd_err_parity", odd_perr_last, 0);

    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    rx = 1'b0;
    tick(6);
    checkOutput("false_start_busy", busy, 1);
    rx = 1'b1;
    tick(OVS);
    checkOutput("false_start_idle", busy, 0);
    checkOutput("false_start_no_valid", rx_valid, 0);

    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("held_valid", rx_valid, 1);
    checkOutput("held_data", rx_data, 8'h11);
    checkOutput("overrun_before", err_overrun, 0);
    applyStimulus(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("overrun_data_kept", rx_data, 8'h11);
    checkOutput("overrun_set", err_overrun, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checkOutput("overrun_cleared", err_overrun, 0);
    rx_ready = 1'b1;
    tick(2);
    checkOutput("drained_valid", rx_valid, 0);

    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    checkOutput("mid_frame_busy", busy, 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    rx = 1'b1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rx_valid", rx_valid, 0);
    checkOutput("midrst_rx_data", rx_data, 0);
    checkOutput("midrst_err_frame", err_frame, 0);
    tick(3 * OVS);
    checkOutput("midrst_no_valid", rx_valid, 0);
    applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef UART_RX_MAJORITY_EN
    begin
      exp_t e;
      e.data = 8'hFF;
      e.perr = 1'b0;
      e.ferr = 1'b0;
      exp_q.push_back(e);
      sendBit(1'b0);
      rx = 1'b1;
      tick(9);
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(OVS - 10);
      for (int i = 1; i < 8; i++) sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      tick(4);
    end
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
